renode_axi_burst_splitter: RTL
==============================

Name: renode_axi_burst_splitter

Overview:
Synthesizable AXI4 stage placed directly upstream of the Renode AXI subordinate, between a DUT manager and the co-simulation bus. Converts every incoming burst (INCR, FIXED or WRAP, any legal length) into a sequence of single-beat INCR transactions, which the subordinate handles natively. Reassembles the responses into one AXI-compliant burst response for the manager. Read and write paths are independent, with one outstanding transaction per direction.

Parameters:
AddressWidth, 32, width of the address buses
DataWidth, 32, width of the data buses; strobe width is DataWidth/8
TransactionIdWidth, 8, width of the ID fields

Ports:
aclk  input  1  clock
areset_n  input  1  reset
s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  input  ID/Addr/8/3/2  upstream write address
s_awvalid input 1; s_awready output 1  upstream AW handshake
s_wdata/s_wstrb/s_wlast/s_wvalid  input  Data/Strb/1/1  upstream write data; s_wready output 1
s_bid/s_bresp/s_bvalid  output  ID/2/1  upstream write response; s_bready input 1
s_arid/s_araddr/s_arlen/s_arsize/s_arburst/s_arvalid  input  ID/Addr/8/3/2/1; s_arready output 1
s_rid/s_rdata/s_rresp/s_rlast/s_rvalid  output  ID/Data/2/1/1; s_rready input 1
m_aw*, m_w*, m_b*, m_ar*, m_r*  same set as the upstream channels, directions mirrored  downstream side toward the subordinate

Behaviour:
- Clock and reset: one clock, aclk. Reset areset_n is asynchronous and active-low.
- Reset state: all *valid and *ready outputs are 0. Response and ID fields are 0. FSMs return to IDLE. Beat counters are 0.
- Reset mid-burst drops the transaction. No further downstream requests or upstream responses are issued for it.
- Handshake rules:
  - Registered outputs hold valid and payload stable until ready.
  - No output valid depends combinationally on the same-channel ready.
- Downstream request fields:
  - m_arlen = m_awlen = 0.
  - m_*burst = INCR (2'b01).
  - m_*size = captured size.
  - m_*id = captured id.
  - m_wlast = 1 on every forwarded beat.
- Beat address, step = 2^size:
  - INCR: next = addr + step.
  - FIXED: next = addr.
  - WRAP: total = (len+1)*step; next = (addr & ~(total-1)) | ((addr+step) & (total-1)).
- Illegal requests:
  - Burst code 2'b11 is illegal.
  - WRAP with len not in {1,3,7,15} is illegal.
  - WRAP with an address not aligned to step is illegal.
- Read FSM states: IDLE, ADDR, DATA, ERR.
  - IDLE: s_arready = 1. On handshake, capture id, addr, len, size and burst, clear the beat counter, then go to ADDR. Go to ERR instead if the request is illegal.
  - ADDR: m_arvalid = 1 from the cycle after capture. On m_arready, go to DATA.
  - DATA: pass-through. s_rvalid = m_rvalid, m_rready = s_rready, s_rdata = m_rdata, s_rresp = m_rresp (EXOKAY is forwarded as OKAY), s_rid = captured id, s_rlast = (beat == len).
  - DATA exit: on the R handshake, if beat == len go to IDLE; otherwise increment beat, advance the address and go to ADDR.
  - ERR: issues len+1 beats with rdata 0, rresp SLVERR (2'b10) and rlast on the final beat. No downstream access.
- Write FSM states: IDLE, ADDR, DATA, RESP_WAIT, BRESP, DRAIN.
  - IDLE: s_awready = 1. On handshake, capture the request, clear the beat counter and set the accumulated response acc = OKAY. Go to ADDR, or to DRAIN if the request is illegal.
  - ADDR: m_awvalid until m_awready.
  - DATA: pass-through. m_wvalid = s_wvalid, s_wready = m_wready, m_wdata/m_wstrb from upstream. On handshake, go to RESP_WAIT.
  - RESP_WAIT: m_bready = 1. On m_bvalid, set acc = max(acc, m_bresp) with EXOKAY counted as OKAY, so DECERR > SLVERR > OKAY.
  - RESP_WAIT exit: if beat == len, go to BRESP; otherwise increment beat, advance the address and go to ADDR.
  - s_wlast check: if s_wlast differs from (beat == len), set acc to at least SLVERR. The beat is still forwarded.
  - DRAIN: s_wready = 1 until the s_wlast handshake, with no downstream traffic. Then set acc = SLVERR and go to BRESP.
  - BRESP: s_bvalid = 1 with s_bid = captured id and s_bresp = acc. Hold until s_bready, then go to IDLE.
- Read and write transactions may be in flight simultaneously. No ordering is enforced between them.
- len = 255 must not overflow the 8-bit beat counter comparison.
- Address arithmetic wraps modulo 2^AddressWidth.

Test Plan:
- INCR read: araddr 0x100, arlen 3, arsize 2 -> downstream ARs at 0x100, 0x104, 0x108, 0x10C, each with arlen 0. Upstream receives 4 R beats with the original ID; rlast only on beat 4.
- WRAP read: araddr 0x108, arlen 3, arsize 2 -> downstream ARs at 0x108, 0x10C, 0x100, 0x104.
- FIXED write: awaddr 0x40, awlen 2, data 0xA, 0xB, 0xC -> three AW/W pairs at 0x40, each with wlast = 1. A single B with bresp OKAY follows the third downstream B.
- Write-error merge: awlen 3, downstream bresp SLVERR on beat 2, OKAY otherwise -> all 4 beats are still forwarded; one upstream bresp 2'b10.
- Illegal bursts:
  - Read with burst 2'b11, arlen 1 -> no m_arvalid; 2 R beats with rdata 0, rresp 2'b10, rlast on beat 2.
  - WRAP write with awlen 2 -> W beats drained; bresp 2'b10.
- Backpressure and reset: hold s_rready = 0 mid-burst, then pulse areset_n low -> all valids drop asynchronously. After release, a new arlen 0 read completes normally.

Source files
------------

// File: rtl/renode_axi_burst_splitter.sv
// renode_axi_burst_splitter
//
// AXI4 stage in front of the Renode AXI subordinate. Every upstream burst (INCR, FIXED or WRAP)
// is replayed downstream as a sequence of single-beat INCR transactions. The per-beat responses
// are reassembled into one AXI-compliant burst response for the upstream manager. The read and
// write paths are independent, and each direction has at most one transaction in flight.
//
// Ports
//   aclk, areset_n         clock; asynchronous active-low reset
//   s_aw*, s_w*, s_b*      upstream write address / data / response (subordinate side)
//   s_ar*, s_r*            upstream read address / data (subordinate side)
//   m_aw*, m_w*, m_b*      downstream write channels (manager side, toward Renode)
//   m_ar*, m_r*            downstream read channels (manager side, toward Renode)
module renode_axi_burst_splitter #(
    parameter int unsigned AddressWidth       = 32,
    parameter int unsigned DataWidth          = 32,
    parameter int unsigned TransactionIdWidth = 8
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    // Upstream write address
    input  logic [TransactionIdWidth-1:0] s_awid,
    input  logic [AddressWidth-1:0]       s_awaddr,
    input  logic [7:0]                    s_awlen,
    input  logic [2:0]                    s_awsize,
    input  logic [1:0]                    s_awburst,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    // Upstream write data
    input  logic [DataWidth-1:0]          s_wdata,
    input  logic [DataWidth/8-1:0]        s_wstrb,
    input  logic                          s_wlast,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    // Upstream write response
    output logic [TransactionIdWidth-1:0] s_bid,
    output logic [1:0]                    s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,
    // Upstream read address
    input  logic [TransactionIdWidth-1:0] s_arid,
    input  logic [AddressWidth-1:0]       s_araddr,
    input  logic [7:0]                    s_arlen,
    input  logic [2:0]                    s_arsize,
    input  logic [1:0]                    s_arburst,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    // Upstream read data
    output logic [TransactionIdWidth-1:0] s_rid,
    output logic [DataWidth-1:0]          s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic                          s_rvalid,
    input  logic                          s_rready,
    // Downstream write address
    output logic [TransactionIdWidth-1:0] m_awid,
    output logic [AddressWidth-1:0]       m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    // Downstream write data
    output logic [DataWidth-1:0]          m_wdata,
    output logic [DataWidth/8-1:0]        m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    // Downstream write response
    input  logic [TransactionIdWidth-1:0] m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    // Downstream read address
    output logic [TransactionIdWidth-1:0] m_arid,
    output logic [AddressWidth-1:0]       m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    // Downstream read data
    input  logic [TransactionIdWidth-1:0] m_rid,
    input  logic [DataWidth-1:0]          m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {RdIdle, RdAddr, RdData, RdErr} rd_state_e;
    typedef enum logic [2:0] {WrIdle, WrAddr, WrData, WrRespWait, WrBresp, WrDrain} wr_state_e;

    // Address of the beat following addr within the original burst.
    function automatic logic [AddressWidth-1:0] beat_next_addr(
        input logic [AddressWidth-1:0] addr,
        input logic [2:0]              size,
        input logic [7:0]              len,
        input logic [1:0]              burst
    );
        logic [AddressWidth-1:0] step;
        logic [AddressWidth-1:0] wrap_mask;
        step      = AddressWidth'(1) << size;
        wrap_mask = ((AddressWidth'(len) + AddressWidth'(1)) << size) - AddressWidth'(1);
        case (burst)
            BurstFixed: beat_next_addr = addr;
            BurstWrap:  beat_next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    beat_next_addr = addr + step;
        endcase
    endfunction

    function automatic logic burst_illegal(
        input logic [AddressWidth-1:0] addr,
        input logic [2:0]              size,
        input logic [7:0]              len,
        input logic [1:0]              burst
    );
        logic [AddressWidth-1:0] step_mask;
        logic                    wrap_len_ok;
        step_mask     = (AddressWidth'(1) << size) - AddressWidth'(1);
        wrap_len_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_illegal = (burst == 2'b11) ||
                        ((burst == BurstWrap) && (!wrap_len_ok || ((addr & step_mask) != '0)));
    endfunction

    // EXOKAY folds to OKAY; after that the codes order by severity: OKAY < SLVERR < DECERR.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] a_n;
        logic [1:0] b_n;
        a_n        = (a == RespExOkay) ? RespOkay : a;
        b_n        = (b == RespExOkay) ? RespOkay : b;
        resp_merge = (a_n > b_n) ? a_n : b_n;
    endfunction

    // Keeps the upstream address readies low while reset is applied and for the first cycle after.
    logic rdy_en_q, rdy_en_d;

    rd_state_e                     rd_state_q, rd_state_d;
    logic [TransactionIdWidth-1:0] ar_id_q, ar_id_d;
    logic [AddressWidth-1:0]       ar_addr_q, ar_addr_d;
    logic [7:0]                    ar_len_q, ar_len_d;
    logic [2:0]                    ar_size_q, ar_size_d;
    logic [1:0]                    ar_burst_q, ar_burst_d;
    logic [7:0]                    rd_beat_q, rd_beat_d;
    logic                          rd_last;

    wr_state_e                     wr_state_q, wr_state_d;
    logic [TransactionIdWidth-1:0] aw_id_q, aw_id_d;
    logic [AddressWidth-1:0]       aw_addr_q, aw_addr_d;
    logic [7:0]                    aw_len_q, aw_len_d;
    logic [2:0]                    aw_size_q, aw_size_d;
    logic [1:0]                    aw_burst_q, aw_burst_d;
    logic [7:0]                    wr_beat_q, wr_beat_d;
    logic [1:0]                    wr_acc_q, wr_acc_d;
    logic                          wr_last;

    assign rd_last  = (rd_beat_q == ar_len_q);
    assign wr_last  = (wr_beat_q == aw_len_q);
    assign rdy_en_d = 1'b1;

    // ---------------------------------------------------------------- read path
    always_comb begin
        rd_state_d = rd_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        rd_beat_d  = rd_beat_q;
        s_arready  = rdy_en_q && (rd_state_q == RdIdle);
        m_arvalid  = (rd_state_q == RdAddr);
        m_rready   = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = '0;
        s_rresp    = RespOkay;
        s_rlast    = 1'b0;
        unique case (rd_state_q)
            RdIdle: begin
                if (s_arvalid && s_arready) begin
                    ar_id_d    = s_arid;
                    ar_addr_d  = s_araddr;
                    ar_len_d   = s_arlen;
                    ar_size_d  = s_arsize;
                    ar_burst_d = s_arburst;
                    rd_beat_d  = 8'd0;
                    rd_state_d = burst_illegal(s_araddr, s_arsize, s_arlen, s_arburst) ?
                                 RdErr : RdAddr;
                end
            end
            RdAddr: begin
                if (m_arready) rd_state_d = RdData;
            end
            RdData: begin
                s_rvalid = m_rvalid;
                m_rready = s_rready;
                s_rdata  = m_rdata;
                s_rresp  = (m_rresp == RespExOkay) ? RespOkay : m_rresp;
                s_rlast  = rd_last;
                if (m_rvalid && s_rready) begin
                    if (rd_last) begin
                        rd_state_d = RdIdle;
                    end else begin
                        rd_beat_d  = rd_beat_q + 8'd1;
                        ar_addr_d  = beat_next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
                        rd_state_d = RdAddr;
                    end
                end
            end
            RdErr: begin
                s_rvalid = 1'b1;
                s_rresp  = RespSlvErr;
                s_rlast  = rd_last;
                if (s_rready) begin
                    if (rd_last) rd_state_d = RdIdle;
                    else         rd_beat_d  = rd_beat_q + 8'd1;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    assign s_rid     = ar_id_q;
    assign m_arid    = ar_id_q;
    assign m_araddr  = ar_addr_q;
    assign m_arlen   = 8'd0;
    assign m_arsize  = ar_size_q;
    assign m_arburst = BurstIncr;

    // ---------------------------------------------------------------- write path
    always_comb begin
        wr_state_d = wr_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        wr_beat_d  = wr_beat_q;
        wr_acc_d   = wr_acc_q;
        s_awready  = rdy_en_q && (wr_state_q == WrIdle);
        m_awvalid  = (wr_state_q == WrAddr);
        m_wvalid   = 1'b0;
        s_wready   = 1'b0;
        m_bready   = 1'b0;
        s_bvalid   = 1'b0;
        unique case (wr_state_q)
            WrIdle: begin
                if (s_awvalid && s_awready) begin
                    aw_id_d    = s_awid;
                    aw_addr_d  = s_awaddr;
                    aw_len_d   = s_awlen;
                    aw_size_d  = s_awsize;
                    aw_burst_d = s_awburst;
                    wr_beat_d  = 8'd0;
                    wr_acc_d   = RespOkay;
                    wr_state_d = burst_illegal(s_awaddr, s_awsize, s_awlen, s_awburst) ?
                                 WrDrain : WrAddr;
                end
            end
            WrAddr: begin
                if (m_awready) wr_state_d = WrData;
            end
            WrData: begin
                m_wvalid = s_wvalid;
                s_wready = m_wready;
                if (s_wvalid && m_wready) begin
                    // A misplaced wlast is reported but the beat is still written.
                    if (s_wlast != wr_last) wr_acc_d = resp_merge(wr_acc_q, RespSlvErr);
                    wr_state_d = WrRespWait;
                end
            end
            WrRespWait: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    wr_acc_d = resp_merge(wr_acc_q, m_bresp);
                    if (wr_last) begin
                        wr_state_d = WrBresp;
                    end else begin
                        wr_beat_d  = wr_beat_q + 8'd1;
                        aw_addr_d  = beat_next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
                        wr_state_d = WrAddr;
                    end
                end
            end
            WrDrain: begin
                s_wready = 1'b1;
                if (s_wvalid && s_wlast) begin
                    wr_acc_d   = RespSlvErr;
                    wr_state_d = WrBresp;
                end
            end
            WrBresp: begin
                s_bvalid = 1'b1;
                if (s_bready) wr_state_d = WrIdle;
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    assign s_bid     = aw_id_q;
    assign s_bresp   = wr_acc_q;
    assign m_awid    = aw_id_q;
    assign m_awaddr  = aw_addr_q;
    assign m_awlen   = 8'd0;
    assign m_awsize  = aw_size_q;
    assign m_awburst = BurstIncr;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = 1'b1;

    // Downstream IDs and rlast carry no information for single-beat transfers.
    logic unused_inputs;
    assign unused_inputs = ^{m_bid, m_rid, m_rlast};

    // ---------------------------------------------------------------- state
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rdy_en_q   <= 1'b0;
            rd_state_q <= RdIdle;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            rd_beat_q  <= '0;
            wr_state_q <= WrIdle;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            wr_beat_q  <= '0;
            wr_acc_q   <= RespOkay;
        end else begin
            rdy_en_q   <= rdy_en_d;
            rd_state_q <= rd_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            rd_beat_q  <= rd_beat_d;
            wr_state_q <= wr_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            wr_beat_q  <= wr_beat_d;
            wr_acc_q   <= wr_acc_d;
        end
    end

endmodule
